// File: rtl/ps2_kb_pkg.sv
// Shared constants, state encoding and byte classification for the PS/2 keyboard sequencer.
package ps2_kb_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam logic [7:0] PS2_BAT   = 8'hAA;
   localparam logic [7:0] PS2_ACK   = 8'hFA;

   localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;
   localparam int         EV_W           = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      DEC  = 2'd2
   } kb_state_e;

   // Keyboard protocol responses that never map to a key event.
   function automatic logic is_proto_byte(input logic [7:0] b);
      case (b)
         8'h00, PS2_BAT, 8'hEE, PS2_ACK, 8'hFC, 8'hFE, 8'hFF: is_proto_byte = 1'b1;
         default:                                            is_proto_byte = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_ev_fifo.sv
// Show-ahead event FIFO; a push while full is accepted only when a pop happens on the same edge.
module ps2_ev_fifo
   import ps2_kb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [EV_W-1:0]          wdata,
   input  logic                     pop,
   output logic [EV_W-1:0]          rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [EV_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kb_ctrl.sv
// PS/2 Set-2 scan-code sequencer: drains the receiver, decodes E0/F0/E1 prefixes, queues key events.
// Optional typematic repeat filter enabled by defining PS2_KB_REPEAT_FILT_EN.
module ps2_kb_ctrl
   import ps2_kb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     kb_ready,
   input  logic [7:0]               kb_data,
   output logic                     kb_rdn,
   input  logic                     ev_rd,
   output logic                     ev_valid,
   output logic [EV_W-1:0]          ev_data,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   kb_state_e       state, state_d;
   logic [7:0]      byte_r, byte_d;
   logic            ext, ext_d;
   logic            brk, brk_d;
   logic [2:0]      skip_cnt, skip_d;
   logic            rdn_d;
   logic            dec_push;
   logic            rep_hit;
   logic            fifo_push;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;
   logic            drop;

   always_comb begin
      state_d  = state;
      byte_d   = byte_r;
      ext_d    = ext;
      brk_d    = brk;
      skip_d   = skip_cnt;
      rdn_d    = 1'b1;
      dec_push = 1'b0;
      case (state)
         IDLE: if (kb_ready) begin
            byte_d  = kb_data;
            rdn_d   = 1'b0;
            state_d = ACK;
         end
         ACK: state_d = DEC;
         DEC: begin
            state_d = IDLE;
            if (skip_cnt != '0) begin
               skip_d = skip_cnt - 1'b1;
            end else if (byte_r == PS2_PAUSE) begin
               skip_d = PS2_PAUSE_SKIP;
               ext_d  = 1'b0;
               brk_d  = 1'b0;
            end else if (byte_r == PS2_EXT) begin
               ext_d = 1'b1;
            end else if (byte_r == PS2_BRK) begin
               brk_d = 1'b1;
            end else begin
               dec_push = !is_proto_byte(byte_r);
               ext_d    = 1'b0;
               brk_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         byte_r   <= '0;
         ext      <= 1'b0;
         brk      <= 1'b0;
         skip_cnt <= '0;
         kb_rdn   <= 1'b1;
      end else begin
         state    <= state_d;
         byte_r   <= byte_d;
         ext      <= ext_d;
         brk      <= brk_d;
         skip_cnt <= skip_d;
         kb_rdn   <= rdn_d;
      end
   end

`ifdef PS2_KB_REPEAT_FILT_EN
   logic [8:0] last_make;
   logic       last_vld;
   logic       last_match;

   assign last_match = last_vld && (last_make == {ext, byte_r});
   assign rep_hit    = dec_push && !brk && last_match;

   // Held key: repeats of the same make are suppressed until its break arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_make <= '0;
         last_vld  <= 1'b0;
      end else if (dec_push) begin
         if (!brk && !last_match) begin
            last_make <= {ext, byte_r};
            last_vld  <= 1'b1;
         end else if (brk && last_match) begin
            last_vld  <= 1'b0;
         end
      end
   end
`else
   assign rep_hit = 1'b0;
`endif

   assign fifo_push = dec_push && !rep_hit;
   assign pop       = ev_rd && !fifo_empty;
   assign drop      = fifo_push && fifo_full && !pop;
   assign ev_valid  = !fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   ps2_ev_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata ({brk, ext, byte_r}),
      .pop   (ev_rd),
      .rdata (ev_data),
      .count (ev_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_ps2_kb_ctrl.sv
// Directed self-checking bench for ps2_kb_ctrl with a simple receiver handshake model.
module tb_ps2_kb_ctrl;
   import ps2_kb_pkg::*;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            kb_ready;
   logic [7:0]      kb_data;
   logic            kb_rdn;
   logic            ev_rd;
   logic            ev_valid;
   logic [EV_W-1:0] ev_data;
   logic [CW-1:0]   ev_count;
   logic            ovf;
   logic            ovf_clr;

   int n_cmp = 0;
   int n_err = 0;
   int rdn_low = 0;
   int n_bytes = 0;

   always #5 clk = ~clk;

   ps2_kb_ctrl #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .kb_ready (kb_ready),
      .kb_data  (kb_data),
      .kb_rdn   (kb_rdn),
      .ev_rd    (ev_rd),
      .ev_valid (ev_valid),
      .ev_data  (ev_data),
      .ev_count (ev_count),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   always @(negedge clk) if (rst && !kb_rdn) rdn_low++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a byte, wait for the read strobe, drop ready on the following cycle (DEC).
   // pop_in_dec raises ev_rd for exactly the DEC cycle.
   task automatic send(input logic [7:0] b, input logic pop_in_dec = 1'b0);
      int t = 0;
      kb_data  = b;
      kb_ready = 1'b1;
      n_bytes++;
      @(negedge clk);
      while (kb_rdn && t < 8) begin
         @(negedge clk);
         t++;
      end
      if (kb_rdn) chk("rdn_timeout", 32'd1, 32'd0);
      @(negedge clk);
      kb_ready = 1'b0;
      ev_rd    = pop_in_dec;
      chk("rdn_width", kb_rdn, 1'b1);
      @(negedge clk);
      ev_rd = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [EV_W-1:0] exp);
      chk(tag, ev_data, exp);
      ev_rd = 1'b1;
      @(negedge clk);
      ev_rd = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; kb_ready = 1'b0; kb_data = '0; ev_rd = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rdn",   kb_rdn,   1'b1);
      chk("rst_valid", ev_valid, 1'b0);
      chk("rst_data",  ev_data,  10'h000);
      chk("rst_count", ev_count, 0);
      chk("rst_ovf",   ovf,      1'b0);
      rst = 1'b1;
      @(negedge clk);

      // Make then break; also check event latency around the DEC edge
      kb_data = 8'h1C; kb_ready = 1'b1;
      @(negedge clk);                     // edge N taken
      chk("rdn_low", kb_rdn, 1'b0);
      @(negedge clk);                     // after N+1 (DEC cycle)
      kb_ready = 1'b0;
      chk("lat_pre", ev_valid, 1'b0);
      @(negedge clk);                     // after N+2
      chk("lat_post", ev_valid, 1'b1);
      n_bytes++;
      send(8'hF0); send(8'h1C);
      chk("mb_count", ev_count, 2);
      pop_chk("make_1c",  10'h01C);
      pop_chk("break_1c", 10'h21C);
      chk("rdn_pulses", rdn_low, n_bytes);

      // Extended make/break
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_count", ev_count, 2);
      pop_chk("ext_make",  10'h175);
      pop_chk("ext_break", 10'h375);

      // Pause sequence swallowed entirely
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h1C);
      chk("pause_count", ev_count, 1);
      pop_chk("pause_next", 10'h01C);
      chk("pause_empty", ev_valid, 1'b0);

      // Protocol bytes discarded
      send(8'hAA); send(8'hFA); send(8'h29);
      chk("proto_count", ev_count, 1);
      pop_chk("proto_29", 10'h029);

      // Pop while empty is ignored
      pop_chk("empty_data", 10'h000);
      chk("empty_count", ev_count, 0);

      // Overflow: 9 makes 0x15..0x1D, last is dropped
      for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
      chk("full_count", ev_count, 8);
      chk("full_ovf",   ovf,      1'b1);
      chk("full_head",  ev_data,  10'h015);
      send(8'h1E, 1'b1);
      chk("pp_count", ev_count, 8);
      chk("pp_head",  ev_data,  10'h016);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_clr", ovf, 1'b0);
      for (int i = 0; i < 7; i++) pop_chk("drain", 10'h016 + 10'(i));
      pop_chk("drain_last", 10'h01E);
      chk("drain_empty", ev_valid, 1'b0);

      // Reset between prefix and code clears the extended flag
      send(8'hE0);
      do_reset();
      send(8'h75);
      chk("rst_mid_count", ev_count, 1);
      pop_chk("rst_mid_ev", 10'h075);

      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
`ifdef PS2_KB_REPEAT_FILT_EN
      chk("rep_count", ev_count, 2);
      pop_chk("rep_make",  10'h01C);
      pop_chk("rep_break", 10'h21C);
      chk("rep_ovf", ovf, 1'b0);
`else
      chk("rep_count", ev_count, 4);
      pop_chk("rep_m0", 10'h01C);
      pop_chk("rep_m1", 10'h01C);
      pop_chk("rep_m2", 10'h01C);
      pop_chk("rep_break", 10'h21C);
`endif
      chk("final_empty", ev_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
